// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU-side memory controller: size defaults,
// FSM state encoding and the response-error encoding.
package mem_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned MEM_DEPTH_DEF  = 16384;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } mc_state_e;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/memory_controller.sv
// Single-outstanding CPU-to-main-memory controller: latches a request into
// MAR/MBR, drives the synchronous memory, and holds the response until taken.
module memory_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    mc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic                  wr_q, wr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  req_ready_q, req_ready_d;
    logic                  addr_in_range;

    // Unsigned range check, widened so any ADDR_WIDTH/MEM_DEPTH pairing compares safely
    assign addr_in_range = 64'(req_addr) < 64'(MEM_DEPTH);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mar_q       <= '0;
            mbr_q       <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= RSP_OK;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mbr_q       <= mbr_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Next-state and next-output logic; write enable is a one-cycle pulse by default-low
    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mbr_d       = mbr_q;
        wr_d        = wr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_d    = 1'b0;
        req_ready_d = req_ready_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    mar_d       = req_addr;
                    mbr_d       = req_wdata;
                    wr_d        = req_write;
                    req_ready_d = 1'b0;
                    if (addr_in_range) begin
                        state_d  = ACCESS;
                        mem_we_d = req_write;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = RSP_ERR;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = RSP_OK;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Memory read data is valid one cycle after the address was presented
                mbr_d       = mem_data_out;
                rsp_rdata_d = mem_data_out;
                rsp_error_d = RSP_OK;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_error        = rsp_error_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign mem_addr         = mar_q;
    assign mem_data_in      = mbr_q;
    assign mem_write_enable = mem_we_q;

endmodule
